bridge_tx: RTL and testbench

//  Terminal stage of the register-bus chain. Consumes the bus transaction emitted by the last core.

---
 rtl/bridge_pkg.sv | 34 +++
 rtl/bridge_tx_if.sv | 27 ++
 rtl/resp_fifo.sv | 62 ++++++
 rtl/bridge_tx.sv | 110 +++++++++++
 tb/tb_bridge_tx.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the register-bus bridge (tx serialiser and rx hex decoder).
//   DATA_W / BYTE_W : bus word and stream byte widths
//   CHAR_*          : ASCII framing characters
//   tx_state_e      : serialiser FSM states
//   to_hex          : nibble -> uppercase ASCII hex digit
package bridge_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CHAR_D  = 8'h44;
    localparam logic [BYTE_W-1:0] CHAR_CR = 8'h0D;
    localparam logic [BYTE_W-1:0] CHAR_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_N3,
        ST_N2,
        ST_N1,
        ST_N0,
        ST_CR,
        ST_LF
    } tx_state_e;

    // 0-9 -> '0'-'9', 10-15 -> 'A'-'F' ('A' - 10 == 8'h37)
    function automatic logic [BYTE_W-1:0] to_hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + 8'(nib);
        end
        return 8'h37 + 8'(nib);
    endfunction

endpackage

// File: rtl/bridge_tx_if.sv
// Bus + byte-stream bundle between the last core, bridge_tx and uart_tx.
//   rdata_i/rw_i/valid_i : bus transaction from the last core
//   data_o/valid_o/ready_i : ASCII byte stream to uart_tx
//   overflow_o/busy_o    : status
// slave = bridge_tx side, master = environment side.
interface bridge_tx_if;

    logic [bridge_pkg::DATA_W-1:0] rdata_i;
    logic                          rw_i;
    logic                          valid_i;
    logic [bridge_pkg::BYTE_W-1:0] data_o;
    logic                          valid_o;
    logic                          ready_i;
    logic                          overflow_o;
    logic                          busy_o;

    modport slave (
        input  rdata_i, rw_i, valid_i, ready_i,
        output data_o, valid_o, overflow_o, busy_o
    );

    modport master (
        output rdata_i, rw_i, valid_i, ready_i,
        input  data_o, valid_o, overflow_o, busy_o
    );

endinterface

// File: rtl/resp_fifo.sv
// Synchronous FIFO holding read responses awaiting serialisation.
//   clk, rst          : clock, synchronous active-high reset (flushes)
//   push_i, wdata_i   : write; accepted when not full, or when full with a pop on the same edge
//   pop_i             : drop head (ignored when empty)
//   rdata_o           : head entry (combinational, valid when !empty_o)
//   full_o, empty_o   : status from extended-pointer compare
module resp_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Same index, different lap bit -> full; identical -> empty
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointer next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/bridge_tx.sv
// Terminal stage of the register-bus chain: queues read responses and serialises each one
// as "D" + 4 uppercase hex digits + CR LF, one byte per valid/ready handshake.
//   clk, rst   : clock, synchronous active-high reset
//   bus.slave  : rdata_i/rw_i/valid_i in, data_o/valid_o (registered) out, ready_i in,
//                overflow_o (sticky, registered), busy_o (decoded from registers)
module bridge_tx
    import bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    bridge_tx_if.slave  bus
);

    tx_state_e          state_q, state_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;

    logic               push;
    logic               pop;
    logic               accept;
    logic [DATA_W-1:0]  fifo_head;
    logic               fifo_full;
    logic               fifo_empty;

    assign push   = bus.valid_i && !bus.rw_i;
    assign accept = valid_q && bus.ready_i;

    resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (bus.rdata_i),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State, word and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Next state: load a word from the FIFO in IDLE, then step one byte per accepted handshake
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    word_d  = fifo_head;
                    state_d = ST_PRE;
                end
            end
            ST_PRE:  if (accept) state_d = ST_N3;
            ST_N3:   if (accept) state_d = ST_N2;
            ST_N2:   if (accept) state_d = ST_N1;
            ST_N1:   if (accept) state_d = ST_N0;
            ST_N0:   if (accept) state_d = ST_CR;
            ST_CR:   if (accept) state_d = ST_LF;
            ST_LF:   if (accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: byte for the state being entered, so the registered byte lines up with state_q
    // and stays stable while stalled (state_d == state_q, word_d == word_q)
    always_comb begin
        valid_d    = (state_d != ST_IDLE);
        data_d     = '0;
        overflow_d = overflow_q || (push && fifo_full && !pop);
        case (state_d)
            ST_PRE:  data_d = CHAR_D;
            ST_N3:   data_d = to_hex(word_d[15:12]);
            ST_N2:   data_d = to_hex(word_d[11:8]);
            ST_N1:   data_d = to_hex(word_d[7:4]);
            ST_N0:   data_d = to_hex(word_d[3:0]);
            ST_CR:   data_d = CHAR_CR;
            ST_LF:   data_d = CHAR_LF;
            default: data_d = '0;
        endcase
    end

    assign bus.data_o     = data_q;
    assign bus.valid_o    = valid_q;
    assign bus.overflow_o = overflow_q;
    assign bus.busy_o     = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_bridge_tx.sv
// Directed bench for bridge_tx: framing, latency, back-pressure, overflow and reset abort.
module tb_bridge_tx;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [7:0] byte_q[$];
    int         stamp_q[$];

    bridge_tx_if bif ();

    bridge_tx #(.FIFO_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every handshake that completes on the coming edge
    always @(negedge clk) begin
        if (bif.valid_o === 1'b1 && bif.ready_i === 1'b1) begin
            byte_q.push_back(bif.data_o);
            stamp_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-cycle bus strobe; returns the cycle index of the edge that sampled it
    task automatic bus_op(input logic rw, input logic [15:0] d, output int p);
        bif.valid_i = 1'b1;
        bif.rw_i    = rw;
        bif.rdata_i = d;
        @(posedge clk); #1;
        p = cyc;
        bif.valid_i = 1'b0;
        bif.rw_i    = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget && byte_q.size() < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_log();
        byte_q.delete();
        stamp_q.delete();
    endtask

    task automatic test_reset();
        n_checks++;
        if (bif.valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", bif.valid_o); end
        n_checks++;
        if (bif.data_o !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h exp 00", bif.data_o); end
        n_checks++;
        if (bif.overflow_o !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b exp 0", bif.overflow_o); end
        n_checks++;
        if (bif.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", bif.busy_o); end
    endtask

    task automatic test_single_read();
        logic [7:0] exp [7];
        logic [7:0] got;
        int p;
        exp = '{8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        clear_log();
        bif.ready_i = 1'b1;
        bus_op(1'b0, 16'hBEEF, p);
        wait_bytes(7, 40);
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (byte_q.size() != 7) begin n_fail++; $display("FAIL single_len: got %0d exp 7", byte_q.size()); end
        for (int i = 0; i < 7; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_checks++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h exp %h", i, got, exp[i]); end
        end
        if (byte_q.size() == 7) begin
            n_checks++;
            if (stamp_q[0] != p + 1) begin n_fail++; $display("FAIL single_latency: got %0d exp %0d", stamp_q[0], p + 1); end
            n_checks++;
            if (stamp_q[6] != p + 7) begin n_fail++; $display("FAIL single_last: got %0d exp %0d", stamp_q[6], p + 7); end
        end
        n_checks++;
        if (bif.valid_o !== 1'b0) begin n_fail++; $display("FAIL single_valid_after: got %b exp 0", bif.valid_o); end
        n_checks++;
        if (bif.busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b exp 0", bif.busy_o); end
    endtask

    task automatic test_write();
        int p;
        int valid_seen = 0;
        int busy_seen = 0;
        clear_log();
        bif.ready_i = 1'b1;
        bus_op(1'b1, 16'h1234, p);
        for (int i = 0; i < 20; i++) begin
            if (bif.valid_o !== 1'b0) valid_seen++;
            if (bif.busy_o !== 1'b0) busy_seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (valid_seen != 0) begin n_fail++; $display("FAIL write_valid: got %0d cycles exp 0", valid_seen); end
        n_checks++;
        if (busy_seen != 0) begin n_fail++; $display("FAIL write_busy: got %0d cycles exp 0", busy_seen); end
        n_checks++;
        if (byte_q.size() != 0) begin n_fail++; $display("FAIL write_bytes: got %0d exp 0", byte_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [14];
        logic [7:0] got;
        int p0, p1;
        exp = '{8'h44, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A,
                8'h44, 8'h30, 8'h39, 8'h41, 8'h46, 8'h0D, 8'h0A};
        clear_log();
        bif.ready_i = 1'b1;
        bus_op(1'b0, 16'h0000, p0);
        bus_op(1'b0, 16'h09AF, p1);
        wait_bytes(14, 60);
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (byte_q.size() != 14) begin n_fail++; $display("FAIL b2b_len: got %0d exp 14", byte_q.size()); end
        for (int i = 0; i < 14; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_checks++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h exp %h", i, got, exp[i]); end
        end
        if (byte_q.size() == 14) begin
            n_checks++;
            if (stamp_q[0] != p0 + 1) begin n_fail++; $display("FAIL b2b_latency: got %0d exp %0d", stamp_q[0], p0 + 1); end
            n_checks++;
            if (stamp_q[7] - stamp_q[6] != 2) begin n_fail++; $display("FAIL b2b_gap: got %0d exp 2", stamp_q[7] - stamp_q[6]); end
            n_checks++;
            if (stamp_q[13] - stamp_q[7] != 6) begin n_fail++; $display("FAIL b2b_frame2_span: got %0d exp 6", stamp_q[13] - stamp_q[7]); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [7];
        logic [7:0] got;
        int p;
        exp = '{8'h44, 8'h41, 8'h35, 8'h43, 8'h33, 8'h0D, 8'h0A};
        clear_log();
        bif.ready_i = 1'b0;
        bus_op(1'b0, 16'hA5C3, p);
        for (int i = 0; i < 10 && bif.valid_o !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bif.valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid%0d: got %b exp 1", i, bif.valid_o); end
            n_checks++;
            if (bif.data_o !== 8'h44) begin n_fail++; $display("FAIL stall_data%0d: got %h exp 44", i, bif.data_o); end
            @(negedge clk);
        end
        @(posedge clk); #1;
        bif.ready_i = 1'b1;
        wait_bytes(7, 30);
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (byte_q.size() != 7) begin n_fail++; $display("FAIL stall_len: got %0d exp 7", byte_q.size()); end
        for (int i = 0; i < 7; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_checks++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %h exp %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp [7];
        logic [7:0] got;
        int p;
        clear_log();
        bif.ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus_op(1'b0, 16'(k), p);
            if (k == 8) begin
                n_checks++;
                if (bif.overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full: got %b exp 0", bif.overflow_o); end
            end
        end
        n_checks++;
        if (bif.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b exp 1", bif.overflow_o); end
        n_checks++;
        if (bif.busy_o !== 1'b1) begin n_fail++; $display("FAIL ovf_busy: got %b exp 1", bif.busy_o); end
        bif.ready_i = 1'b1;
        wait_bytes(63, 120);
        repeat (20) begin @(posedge clk); #1; end
        n_checks++;
        if (byte_q.size() != 63) begin n_fail++; $display("FAIL ovf_len: got %0d exp 63", byte_q.size()); end
        for (int f = 0; f < 9; f++) begin
            exp = '{8'h44, 8'h30, 8'h30, 8'h30, 8'h30 + 8'(f), 8'h0D, 8'h0A};
            for (int b = 0; b < 7; b++) begin
                got = (f * 7 + b < byte_q.size()) ? byte_q[f * 7 + b] : 8'hxx;
                n_checks++;
                if (got !== exp[b]) begin n_fail++; $display("FAIL ovf_frame%0d_byte%0d: got %h exp %h", f, b, got, exp[b]); end
            end
        end
        n_checks++;
        if (bif.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b exp 1", bif.overflow_o); end
        n_checks++;
        if (bif.busy_o !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_busy: got %b exp 0", bif.busy_o); end
    endtask

    task automatic test_reset_mid_frame();
        int p;
        int n_after;
        clear_log();
        bif.ready_i = 1'b1;
        bus_op(1'b0, 16'h1111, p);
        bus_op(1'b0, 16'h2222, p);
        bus_op(1'b0, 16'h3333, p);
        bus_op(1'b0, 16'h4444, p);
        // D, N3, N2 accepted -> N1 now presented
        wait_bytes(3, 30);
        n_checks++;
        if (bif.data_o !== 8'h31 || bif.valid_o !== 1'b1) begin
            n_fail++; $display("FAIL midrst_at_n1: got valid=%b data=%h exp valid=1 data=31", bif.valid_o, bif.data_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bif.valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b exp 0", bif.valid_o); end
        n_checks++;
        if (bif.busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b exp 0", bif.busy_o); end
        n_checks++;
        if (bif.overflow_o !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow: got %b exp 0", bif.overflow_o); end
        n_checks++;
        if (bif.data_o !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h exp 00", bif.data_o); end
        rst = 1'b0;
        n_after = byte_q.size();
        repeat (30) begin @(posedge clk); #1; end
        n_checks++;
        if (byte_q.size() != n_after) begin n_fail++; $display("FAIL midrst_no_more: got %0d bytes exp %0d", byte_q.size(), n_after); end
        n_checks++;
        if (bif.busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_later: got %b exp 0", bif.busy_o); end
    endtask

    initial begin
        rst         = 1'b1;
        bif.rdata_i = '0;
        bif.rw_i    = 1'b0;
        bif.valid_i = 1'b0;
        bif.ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();

        test_single_read();
        test_write();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_reset_mid_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
